// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit bridge:
//                serializer state encoding, default baud divider and
//                frame-shape constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Serializer state encoding, 2 bits wide
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // 50 MHz system clock / 115200 baud
    localparam int C_DEFAULT_CLKS_PER_BIT = 434;

    // 8N1 framing
    localparam int C_DATA_BITS = 8;
    localparam int C_STOP_BITS = 1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_bridge_if
//  Description : Core-side byte write port plus status and serial line of
//                the UART transmit bridge. The core (master) drives the write
//                strobe and byte; the bridge (slave) returns status and txd.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_bridge_if;

    logic       uart_wrreq;
    logic [7:0] uart_out;
    logic       full;
    logic       busy;
    logic       overflow;
    logic       txd;

    modport master (
        output uart_wrreq,
        output uart_out,
        input  full,
        input  busy,
        input  overflow,
        input  txd
    );

    modport slave (
        input  uart_wrreq,
        input  uart_out,
        output full,
        output busy,
        output overflow,
        output txd
    );

endinterface : uart_tx_bridge_if
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO, 2^AW entries, registered read data and
//                synchronous active-high reset. Full/empty derive from the
//                registered occupancy count, so a pop never frees space for a
//                write at the same edge, and a write is never readable before
//                the following edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              wr_en,
    input  wire  [WIDTH-1:0] wr_data,
    input  wire              rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] C_FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem_q [2**AW];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign full    = (count_q == C_FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = rd_data_q;
    assign w_wr_ok = wr_en & ~full;
    assign w_rd_ok = rd_en & ~empty;

    // Pointer, occupancy and read-register next-state
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (w_wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_ok) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem_q[rd_ptr_q];
        end
        case ({w_wr_ok, w_rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_bridge
//  Description : Buffers bytes written by the core into a FIFO and serializes
//                them as 8N1 frames on txd. Frames leave back to back while
//                the FIFO has data. Writes while full are dropped and latch a
//                sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_bridge
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = C_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = 4
) (
    input wire               clk,
    input wire               rst,
    uart_tx_bridge_if.slave  bus
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(C_DATA_BITS);

    tx_state_e              state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [C_DATA_BITS-2:0] shift_q, shift_d;
    logic                   txd_q, txd_d;
    logic                   overflow_q, overflow_d;

    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [7:0]             w_head;
    logic [FIFO_AW:0]       w_count;
    logic                   w_baud_wrap;

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.uart_wrreq),
        .wr_data (bus.uart_out),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign w_baud_wrap  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign bus.full     = w_full;
    assign bus.busy     = (state_q != ST_IDLE) | (w_count != '0);
    assign bus.overflow = overflow_q;
    assign bus.txd      = txd_q;

    // Serializer next-state: the popped byte lands in the FIFO read register
    // one edge after the pop and is transferred to the shifter when the
    // start bit ends, so the data bits never need a bypass path.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        w_pop   = 1'b0;
        if (state_q == ST_IDLE || w_baud_wrap) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = ST_START;
                    bit_d   = '0;
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (w_baud_wrap) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    txd_d   = w_head[0];
                    shift_d = w_head[7:1];
                end
            end
            ST_DATA: begin
                if (w_baud_wrap) begin
                    if (bit_q == BIT_W'(C_DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                        bit_d   = '0;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[C_DATA_BITS-2:1]};
                    end
                end
            end
            ST_STOP: begin
                if (w_baud_wrap) begin
                    if (bit_q == BIT_W'(C_STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (!w_empty) begin
                            w_pop   = 1'b1;
                            state_d = ST_START;
                            txd_d   = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Sticky drop flag: a strobe seen while full is a lost byte
    always_comb begin
        overflow_d = overflow_q | (bus.uart_wrreq & w_full);
    end

    // Serializer and status registers; txd idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
        end
    end

endmodule : uart_tx_bridge
`default_nettype wire

// File: tb/tb_uart_tx_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_bridge
//  Description : Self-checking bench for uart_tx_bridge at 4 clocks per bit:
//                table of single-frame vectors, then directed back-to-back,
//                FIFO-fill, pop/write collision, mid-frame reset and random
//                traffic sequences checked by a reference receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_bridge;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_bridge_if bus ();

    uart_tx_bridge #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (bus.busy && n < max) begin
            tick(1);
            n++;
        end
        check("wait_idle_bound", bus.busy, 1'b0);
    endtask

    // ---------------- reference 8N1 receiver (samples every cycle) --------
    int         cyc = 0;
    bit         rx_en = 1'b1;
    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    logic       rx_s[40];
    int         rx_t0;
    logic       rx_ok;
    logic [7:0] rx_byte;

    always @(negedge clk) cyc <= cyc + 1;

    always begin : rx_model
        @(negedge clk);
        if (rx_en && !rst && bus.txd === 1'b0) begin
            rx_t0    = cyc;
            rx_s[0]  = bus.txd;
            for (int i = 1; i < 40; i++) begin
                @(negedge clk);
                rx_s[i] = bus.txd;
            end
            rx_ok = 1'b1;
            for (int b = 0; b < 10; b++)
                for (int j = 1; j < CPB; j++)
                    if (rx_s[4*b+j] !== rx_s[4*b]) rx_ok = 1'b0;
            if (rx_s[0] !== 1'b0 || rx_s[36] !== 1'b1) rx_ok = 1'b0;
            for (int b = 0; b < 8; b++) rx_byte[b] = rx_s[4*(b+1)];
            check("rx_frame_shape", rx_ok, 1'b1);
            rx_q.push_back(rx_byte);
            rx_start_q.push_back(rx_t0);
        end
    end

    // ---------------- vector table ----------------------------------------
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit0 = start, bits 1..8 = data LSB first, bit9 = stop
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin : main
        int         n;
        int         zeros;
        int         w;
        logic [7:0] b;
        logic [7:0] exp_q[$];

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};
        vecs[5] = '{8'h5A, 10'b1010110100};

        bus.uart_wrreq = 1'b0;
        bus.uart_out   = 8'h00;

        // ---- reset state
        rst = 1'b1;
        tick(3);
        check("reset_txd", bus.txd, 1'b1);
        check("reset_full", bus.full, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_overflow", bus.overflow, 1'b0);
        rst = 1'b0;
        tick(2);
        check("idle_txd", bus.txd, 1'b1);

        // ---- single frames from the table
        for (int v = 0; v < 6; v++) begin
            rx_q.delete();
            rx_start_q.delete();
            bus.uart_wrreq = 1'b1;
            bus.uart_out   = vecs[v].data;
            tick(1);
            bus.uart_wrreq = 1'b0;
            check($sformatf("v%0d_txd_before_start", v), bus.txd, 1'b1);
            check($sformatf("v%0d_busy_queued", v), bus.busy, 1'b1);
            for (int i = 0; i < 40; i++) begin
                tick(1);
                check($sformatf("v%0d_txd_cycle%0d", v, i), bus.txd, vecs[v].frame[i/4]);
            end
            check($sformatf("v%0d_busy_last_stop", v), bus.busy, 1'b1);
            tick(1);
            check($sformatf("v%0d_busy_done", v), bus.busy, 1'b0);
            check($sformatf("v%0d_txd_idle", v), bus.txd, 1'b1);
            check($sformatf("v%0d_rx_count", v), rx_q.size(), 1);
            check($sformatf("v%0d_rx_byte", v), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, vecs[v].data);
            tick(3);
        end

        // ---- two consecutive writes: back-to-back frames, 80 cycles total
        rx_q.delete();
        rx_start_q.delete();
        bus.uart_wrreq = 1'b1;
        bus.uart_out   = 8'h00;
        tick(1);
        bus.uart_out   = 8'hFF;
        tick(1);
        bus.uart_wrreq = 1'b0;
        wait_idle(200, n);
        check("b2b_total_cycles", n, 80);
        tick(2);
        check("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_rx_first", rx_q[0], 8'h00);
            check("b2b_rx_second", rx_q[1], 8'hFF);
            check("b2b_no_gap", rx_start_q[1] - rx_start_q[0], 40);
        end

        // ---- fill: 17 writes from idle. The first byte leaves the FIFO one
        //      edge after it was written, so the 17th still finds room and
        //      full rises with 16 held; then a write coinciding with the
        //      STOP->START pop must be dropped.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rx_q.delete();
        rx_start_q.delete();
        exp_q.delete();
        for (int i = 0; i < 17; i++) begin
            bus.uart_wrreq = 1'b1;
            bus.uart_out   = 8'(i);
            exp_q.push_back(8'(i));
            tick(1);
            if (i == 15) check("fill_not_full_at_15", bus.full, 1'b0);
        end
        bus.uart_wrreq = 1'b0;
        check("fill_full_at_16", bus.full, 1'b1);
        check("fill_no_overflow", bus.overflow, 1'b0);
        tick(24);
        check("fill_still_full", bus.full, 1'b1);
        bus.uart_wrreq = 1'b1;
        bus.uart_out   = 8'hEE;
        tick(1);
        bus.uart_wrreq = 1'b0;
        check("collide_overflow", bus.overflow, 1'b1);
        check("collide_count15_not_full", bus.full, 1'b0);
        bus.uart_wrreq = 1'b1;
        bus.uart_out   = 8'h77;
        exp_q.push_back(8'h77);
        tick(1);
        bus.uart_wrreq = 1'b0;
        check("refill_full", bus.full, 1'b1);
        wait_idle(1000, n);
        check("fill_drain_cycles", n, 679);
        tick(2);
        check("fill_overflow_sticky", bus.overflow, 1'b1);
        check("fill_rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("fill_rx_byte%0d", i), rx_q[i], exp_q[i]);
        for (int i = 1; i < rx_start_q.size(); i++)
            check($sformatf("fill_spacing%0d", i), rx_start_q[i] - rx_start_q[i-1], 40);

        // ---- reset during data bit 3 of 0x3C with 5 bytes queued
        rx_en = 1'b0;
        bus.uart_wrreq = 1'b1;
        bus.uart_out   = 8'h3C;
        tick(1);
        for (int i = 1; i < 6; i++) begin
            bus.uart_out = 8'(8'h10 * i + i);
            tick(1);
        end
        bus.uart_wrreq = 1'b0;
        tick(13);
        check("rstmid_busy_before", bus.busy, 1'b1);
        check("rstmid_bit3_level", bus.txd, 1'b1);
        rst = 1'b1;
        tick(1);
        check("rstmid_txd", bus.txd, 1'b1);
        check("rstmid_busy", bus.busy, 1'b0);
        check("rstmid_full", bus.full, 1'b0);
        check("rstmid_overflow", bus.overflow, 1'b0);
        rst = 1'b0;
        zeros = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (bus.txd !== 1'b1) zeros++;
        end
        check("rstmid_no_frames", zeros, 0);
        check("rstmid_idle_after", bus.busy, 1'b0);
        rx_en = 1'b1;

        // ---- random traffic, writer avoids overflow by polling full
        rx_q.delete();
        rx_start_q.delete();
        exp_q.delete();
        for (int k = 0; k < 200; k++) begin
            tick($urandom_range(0, 60));
            w = 0;
            while (bus.full && w < 100) begin
                tick(1);
                w++;
            end
            b = 8'($urandom_range(0, 255));
            bus.uart_wrreq = 1'b1;
            bus.uart_out   = b;
            exp_q.push_back(b);
            tick(1);
            bus.uart_wrreq = 1'b0;
        end
        wait_idle(20000, n);
        tick(2);
        check("rand_no_overflow", bus.overflow, 1'b0);
        check("rand_rx_count", rx_q.size(), 200);
        for (int i = 0; i < 200 && i < rx_q.size(); i++)
            check($sformatf("rand_rx_byte%0d", i), rx_q[i], exp_q[i]);
        for (int i = 1; i < rx_start_q.size(); i++)
            check($sformatf("rand_spacing%0d", i), (rx_start_q[i] - rx_start_q[i-1]) >= 40, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_bridge
`default_nettype wire
